lab9_soc_button_ctrl: RTL and testbench

Debounce, edge-capture and interrupt controller for the DE2 push-button inputs feeding the lab9 SoC. It sits between the raw KEY pins and the Avalon-MM fabric. It synchronises and debounces each button, latches press events in a sticky capture register, and raises a level interrupt to the Nios II. Software reads debounced state and clears events through a four-word register map, with the same one-cycle registered read latency as the existing PIO slaves.

---
 rtl/lab9_button_pkg.sv | 16 +
 rtl/lab9_button_debounce.sv | 82 ++++++++
 rtl/lab9_soc_button_ctrl.sv | 80 ++++++++
 tb/tb_lab9_soc_button_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lab9_button_pkg.sv
// Shared constants and types for the lab9 push-button controller.
package lab9_button_pkg;

  // Avalon word addresses of the register map
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Per-bit debounce FSM states
  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_CHECK = 1'b1
  } db_state_e;

endpackage

// File: rtl/lab9_button_debounce.sv
// Single-bit synchroniser plus debounce FSM; db only follows the pin after
// it has been stable for DEBOUNCE_CYCLES cycles.
module lab9_button_debounce
  import lab9_button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic db
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync;
  db_state_e        state_q;
  db_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             db_q;
  logic             db_d;
  logic             differ;

  assign differ = (sync != db_q);
  assign db     = db_q;

  // Two-flop synchroniser for the asynchronous pin; idles at released (1)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b1;
      sync      <= 1'b1;
    end else begin
      sync_meta <= pin;
      sync      <= sync_meta;
    end
  end

  // State, counter and accepted-value registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      db_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  // Next-state: leave IDLE on any difference, return on glitch or acceptance
  always_comb begin
    state_d = state_q;
    case (state_q)
      DB_IDLE:  if (differ) state_d = DB_CHECK;
      DB_CHECK: if (!differ || (cnt_q == CNT_LAST)) state_d = DB_IDLE;
      default:  state_d = DB_IDLE;
    endcase
  end

  // Counter and db update; counter stops at CNT_LAST so it cannot wrap
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    case (state_q)
      DB_IDLE: begin
        if (differ) cnt_d = CNT_W'(1);
      end
      DB_CHECK: begin
        if (differ) begin
          if (cnt_q == CNT_LAST) db_d = sync;
          else                   cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      default: cnt_d = '0;
    endcase
  end

endmodule

// File: rtl/lab9_soc_button_ctrl.sv
// Push-button debounce, press capture and interrupt slave for the lab9 SoC.
module lab9_soc_button_ctrl
  import lab9_button_pkg::*;
#(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_prev;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_clr;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  // Upper writedata bits are intentionally ignored
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    lab9_button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .pin   (in_port[i]),
      .db    (db[i])
    );
  end

  assign wr_en       = chipselect & ~write_n;
  assign press       = db_prev & ~db;
  assign edgecap_clr = (wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

  // Press capture, mask register and interrupt; a new press beats a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_prev   <= '1;
      edgecap_q <= '0;
      irqmask_q <= '0;
      irq       <= 1'b0;
    end else begin
      db_prev   <= db;
      edgecap_q <= (edgecap_q & ~edgecap_clr) | press;
      if (wr_en && (address == ADDR_IRQMASK)) irqmask_q <= writedata[WIDTH-1:0];
      irq       <= |(edgecap_q & irqmask_q);
    end
  end

  // Read mux over the register map
  always_comb begin
    rd_mux = 32'h0;
    case (address)
      ADDR_DATA:    rd_mux = 32'(db);
      ADDR_RSVD:    rd_mux = 32'h0;
      ADDR_IRQMASK: rd_mux = 32'(irqmask_q);
      ADDR_EDGECAP: rd_mux = 32'(edgecap_q);
      default:      rd_mux = 32'h0;
    endcase
  end

  // Registered read data, zero when not selected
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= 32'h0;
    else       readdata <= chipselect ? rd_mux : 32'h0;
  end

endmodule

// File: tb/tb_lab9_soc_button_ctrl.sv
// Directed bench for lab9_soc_button_ctrl with WIDTH=2, DEBOUNCE_CYCLES=4.
// Edge numbering: pin changes just after edge 0; db moves at edge 6,
// EDGECAP at edge 7, irq at edge 8, readdata shows a register one edge later.
module tb_lab9_soc_button_ctrl;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned DC    = 4;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic [1:0]  in_port    = 2'b11;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'h0;
  logic [31:0] readdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        cs;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [15];

  lab9_soc_button_ctrl #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    tick();
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    logic [31:0] d;

    // Register access with pins idle; each row is one cycle, readdata shows
    // the register state before that row's edge.
    tbl[0]  = '{1'b1, 1'b1, 2'd2, 32'hFFFF_FFFC, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 2'd2, 32'h3,         32'h0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h3, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 2'd0, 32'h0,         32'h3, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 32'h0,         32'h3, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 2'd1, 32'h0,         32'h0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 2'd2, 32'h0,         32'h0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h3, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 2'd3, 32'h0,         32'h0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h3, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 32'h0,         32'h3, 1'b0};

    // Reset held three cycles with a read pending
    chipselect = 1'b1;
    idle(3);
    check("reset readdata", readdata, 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    chipselect = 1'b0;
    reset = 1'b0;
    rd_reg(2'd0, d);
    check("post-reset DATA", d, 32'h3);

    for (int i = 0; i < 15; i++) begin
      chipselect = tbl[i].cs;
      write_n    = ~tbl[i].wr;
      address    = tbl[i].addr;
      writedata  = tbl[i].wdata;
      tick();
      check($sformatf("tbl[%0d] readdata", i), readdata, tbl[i].exp_rd);
      check($sformatf("tbl[%0d] irq", i), 32'(irq), 32'(tbl[i].exp_irq));
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    // Clean press on button 0 with DATA polled every cycle
    chipselect = 1'b1;
    address    = 2'd0;
    in_port    = 2'b10;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) check("press DATA edge6", readdata, 32'h3);
      if (k == 7) check("press DATA edge7", readdata, 32'h2);
    end
    chipselect = 1'b0;
    rd_reg(2'd3, d);
    check("press EDGECAP", d, 32'h1);
    check("press irq masked", 32'(irq), 32'h0);
    wr_reg(2'd3, 32'h1);
    rd_reg(2'd3, d);
    check("EDGECAP cleared", d, 32'h0);
    in_port = 2'b11;
    idle(10);
    rd_reg(2'd0, d);
    check("release DATA", d, 32'h3);
    rd_reg(2'd3, d);
    check("release no event", d, 32'h0);

    // Glitches of 2 and 3 cycles are rejected, 4 cycles is accepted
    in_port = 2'b01;
    idle(2);
    in_port = 2'b11;
    idle(10);
    rd_reg(2'd0, d);
    check("glitch2 DATA", d, 32'h3);
    rd_reg(2'd3, d);
    check("glitch2 EDGECAP", d, 32'h0);
    in_port = 2'b01;
    idle(3);
    in_port = 2'b11;
    idle(10);
    rd_reg(2'd3, d);
    check("glitch3 EDGECAP", d, 32'h0);
    in_port = 2'b01;
    idle(4);
    in_port = 2'b11;
    idle(12);
    rd_reg(2'd3, d);
    check("pulse4 EDGECAP", d, 32'h2);
    wr_reg(2'd3, 32'h2);
    rd_reg(2'd3, d);
    check("pulse4 cleared", d, 32'h0);

    // Interrupt path on button 1
    wr_reg(2'd2, 32'h3);
    chipselect = 1'b1;
    address    = 2'd3;
    in_port    = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) check("irq edge7", 32'(irq), 32'h0);
      if (k == 8) check("irq edge8", 32'(irq), 32'h1);
      if (k == 8) check("EDGECAP edge8", readdata, 32'h2);
    end
    chipselect = 1'b0;
    wr_reg(2'd3, 32'h2);
    check("irq on clear edge", 32'(irq), 32'h1);
    rd_reg(2'd3, d);
    check("irq after clear", 32'(irq), 32'h0);
    check("EDGECAP after clear", d, 32'h0);
    in_port = 2'b11;
    idle(10);

    // Clear of EDGECAP[0] on the same edge as a new press on button 0
    in_port = 2'b10;
    idle(10);
    rd_reg(2'd3, d);
    check("first press EDGECAP", d, 32'h1);
    check("first press irq", 32'(irq), 32'h1);
    in_port = 2'b11;
    idle(10);
    check("irq after release", 32'(irq), 32'h1);
    in_port = 2'b10;
    idle(6);
    wr_reg(2'd3, 32'h1);
    tick();
    check("set wins irq", 32'(irq), 32'h1);
    rd_reg(2'd3, d);
    check("set wins EDGECAP", d, 32'h1);
    wr_reg(2'd3, 32'h1);
    rd_reg(2'd3, d);
    check("plain clear EDGECAP", d, 32'h0);
    check("plain clear irq", 32'(irq), 32'h0);

    // Reset in the middle of a debounce, pin kept low throughout
    in_port = 2'b11;
    idle(10);
    in_port = 2'b10;
    idle(4);
    reset = 1'b1;
    #1;
    check("mid reset readdata", readdata, 32'h0);
    check("mid reset irq", 32'(irq), 32'h0);
    chipselect = 1'b1;
    address    = 2'd3;
    idle(3);
    check("held reset EDGECAP", readdata, 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) check("post-reset EDGECAP edge7", readdata, 32'h0);
      if (k == 8) check("post-reset EDGECAP edge8", readdata, 32'h1);
    end
    chipselect = 1'b0;
    rd_reg(2'd2, d);
    check("IRQMASK after reset", d, 32'h0);
    check("irq masked after reset", 32'(irq), 32'h0);
    rd_reg(2'd0, d);
    check("DATA held low", d, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
